// File: rtl/xge_loopback_pkg.sv
// Shared types and constants for the 10GE packet loopback bridge.
package xge_loopback_pkg;

    localparam int BYTES_PER_BEAT = 8;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
        logic        err;
    } beat_t;

    typedef enum logic {IDLE = 1'b0, READ = 1'b1} rd_state_t;

    // A mod of zero on the eop beat means the whole beat is valid.
    function automatic logic [3:0] eop_bytes(input logic [2:0] mod);
        return (mod == 3'd0) ? 4'(BYTES_PER_BEAT) : {1'b0, mod};
    endfunction

endpackage

// File: rtl/xge_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data and a free-slot count.
module xge_sync_fifo #(
    parameter type beat_t     = logic [7:0],
    parameter int  FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  beat_t                         push_data,
    input  logic                          pop,
    output beat_t                         pop_data,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   free
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(FIFO_DEPTH);

    beat_t         mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push  = push & (count != DEPTH_W);
    assign do_pop   = pop & (count != '0);
    assign empty    = (count == '0);
    assign free     = DEPTH_W - count;
    assign pop_data = mem[rd_ptr];

    // Pointers are exactly AW bits wide, so they wrap modulo the depth for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/xge_pkt_loopback.sv
// Cut-through loopback: reads MAC RX packets, buffers beats, replays them on MAC TX,
// and keeps saturating RX statistics including SOP/EOP framing violations.
module xge_pkt_loopback
    import xge_loopback_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clk_156m25,
    input  logic             reset_156m25_n,
    input  logic             enable,
    input  logic             pkt_rx_avail,
    output logic             pkt_rx_ren,
    input  logic [63:0]      pkt_rx_data,
    input  logic             pkt_rx_sop,
    input  logic             pkt_rx_eop,
    input  logic [2:0]       pkt_rx_mod,
    input  logic             pkt_rx_val,
    input  logic             pkt_rx_err,
    output logic [63:0]      pkt_tx_data,
    output logic             pkt_tx_sop,
    output logic             pkt_tx_eop,
    output logic [2:0]       pkt_tx_mod,
    output logic             pkt_tx_val,
    input  logic             pkt_tx_full,
    output logic [CNT_W-1:0] rx_pkt_cnt,
    output logic [CNT_W-1:0] rx_byte_cnt,
    output logic [CNT_W-1:0] rx_err_cnt,
    output logic [CNT_W-1:0] framing_err_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);

    rd_state_t   state;
    rd_state_t   state_nxt;
    beat_t       rx_beat;
    beat_t       head;
    logic        fifo_empty;
    logic        fifo_pop;
    logic [AW:0] fifo_free;
    logic        rx_last;
    logic        in_pkt;
    logic [1:0]  frm_inc;
    logic [3:0]  byte_inc;
    logic        unused_err;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W - 3){1'b0}}, inc};
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    assign rx_last    = pkt_rx_val & pkt_rx_eop;
    assign rx_beat    = '{data: pkt_rx_data, sop: pkt_rx_sop, eop: pkt_rx_eop,
                          mod: pkt_rx_mod, err: pkt_rx_err};
    assign fifo_pop   = ~fifo_empty & ~pkt_tx_full;
    assign unused_err = head.err;

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) state <= IDLE;
        else                 state <= state_nxt;
    end

    // Two free slots are required because a read requested last cycle may still land.
    always_comb begin
        state_nxt  = state;
        pkt_rx_ren = 1'b0;
        case (state)
            IDLE: if (enable & pkt_rx_avail) state_nxt = READ;
            READ: begin
                pkt_rx_ren = (fifo_free >= (AW + 1)'(2)) & ~rx_last;
                if (rx_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    xge_sync_fifo #(
        .beat_t     (beat_t),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_156m25),
        .rst_n     (reset_156m25_n),
        .push      (pkt_rx_val),
        .push_data (rx_beat),
        .pop       (fifo_pop),
        .pop_data  (head),
        .empty     (fifo_empty),
        .free      (fifo_free)
    );

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            pkt_tx_val  <= 1'b0;
            pkt_tx_data <= '0;
            pkt_tx_sop  <= 1'b0;
            pkt_tx_eop  <= 1'b0;
            pkt_tx_mod  <= '0;
        end else begin
            pkt_tx_val <= fifo_pop;
            if (fifo_pop) begin
                pkt_tx_data <= head.data;
                pkt_tx_sop  <= head.sop;
                pkt_tx_eop  <= head.eop;
                pkt_tx_mod  <= head.mod;
            end
        end
    end

    // sop must match "not inside a packet"; a beat arriving while idle is a separate violation.
    always_comb begin
        frm_inc  = 2'd0;
        byte_inc = 4'd0;
        if (pkt_rx_val) begin
            if (pkt_rx_sop == in_pkt) frm_inc = frm_inc + 2'd1;
            if (state == IDLE)        frm_inc = frm_inc + 2'd1;
            byte_inc = pkt_rx_eop ? eop_bytes(pkt_rx_mod) : 4'(BYTES_PER_BEAT);
        end
    end

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            in_pkt          <= 1'b0;
            rx_pkt_cnt      <= '0;
            rx_byte_cnt     <= '0;
            rx_err_cnt      <= '0;
            framing_err_cnt <= '0;
        end else begin
            if (pkt_rx_val) in_pkt <= ~pkt_rx_eop;
            rx_pkt_cnt      <= sat_add(rx_pkt_cnt, {3'b000, rx_last});
            rx_byte_cnt     <= sat_add(rx_byte_cnt, byte_inc);
            rx_err_cnt      <= sat_add(rx_err_cnt, {3'b000, rx_last & pkt_rx_err});
            framing_err_cnt <= sat_add(framing_err_cnt, {2'b00, frm_inc});
        end
    end

endmodule
